// File: rtl/common_def_pkg.sv
// Shared definitions for the memory-access stage: funct3 width codes and
// the transaction state encoding.
package common_def;

    // funct3 width codes carried on memType
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_lane_format.sv
// Combinational lane handling: legality of an access, store-data lane
// replication with byte enables, and load-data extraction with extension.
module mem_lane_format (
    input  logic [2:0]  mem_type_i,
    input  logic [1:0]  lane_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic        legal_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] load_data_o
);
    import common_def::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Legality: conflicting direction, reserved width, misalignment, unsigned store
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        legal_o = 1'b1;
        if (rd_i && wr_i) legal_o = 1'b0;
        case (mem_type_i)
            MEM_B, MEM_BU: legal_o = legal_o;
            MEM_H, MEM_HU: if (lane_i[0]) legal_o = 1'b0;
            MEM_W:         if (lane_i != 2'b00) legal_o = 1'b0;
            default:       legal_o = 1'b0;
        endcase
        if (wr_i && (mem_type_i == MEM_BU || mem_type_i == MEM_HU)) legal_o = 1'b0;
    end

    // Store formatting: replicate data across lanes, enable only the addressed bytes
    always_comb begin
        wdata_o = store_data_i;
        be_o    = 4'b1111;
        if (wr_i) begin
            case (mem_type_i)
                MEM_B, MEM_BU: begin
                    wdata_o = {4{store_data_i[7:0]}};
                    be_o    = 4'b0001 << lane_i;
                end
                MEM_H, MEM_HU: begin
                    wdata_o = {2{store_data_i[15:0]}};
                    be_o    = 4'b0011 << lane_i;
                end
                default: begin
                    wdata_o = store_data_i;
                    be_o    = 4'b1111;
                end
            endcase
        end
    end

    // Load formatting: pick the addressed byte/halfword and extend to 32 bits
    always_comb begin
        case (lane_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (mem_type_i)
            MEM_B:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  load_data_o = {24'd0, byte_sel};
            MEM_H:   load_data_o = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  load_data_o = {16'd0, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: converts EX/MEM load/store controls into a
// single request/response transaction on the data-memory bus, stalling the
// pipeline until it completes and flagging illegal accesses without a bus cycle.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [2:0]  memType_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] storeData_i,
    output logic        stall_o,
    output logic [31:0] loadData_o,
    output logic        memFault_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rdata_i
);
    import common_def::*;

    mem_state_t  state_q;
    logic [31:0] addr_q;
    logic [1:0]  lane_q;
    logic [2:0]  type_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        req_valid_q;
    logic [31:0] load_data_q;
    logic        mem_fault_q;

    logic        access;
    logic        in_idle;
    logic [2:0]  fmt_type;
    logic [1:0]  fmt_lane;
    logic        fmt_legal;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_load;

    assign access  = memRead_i | memWrite_i;
    assign in_idle = (state_q == IDLE);

    // While idle the formatter sees the live EX/MEM access; afterwards it
    // formats the returning word with the latched width and lane.
    assign fmt_type = in_idle ? memType_i   : type_q;
    assign fmt_lane = in_idle ? addr_i[1:0] : lane_q;

    mem_lane_format u_fmt (
        .mem_type_i   (fmt_type),
        .lane_i       (fmt_lane),
        .rd_i         (memRead_i),
        .wr_i         (memWrite_i),
        .store_data_i (storeData_i),
        .rdata_i      (dmem_rdata_i),
        .legal_o      (fmt_legal),
        .wdata_o      (fmt_wdata),
        .be_o         (fmt_be),
        .load_data_o  (fmt_load)
    );

    // Stall from the cycle a legal access appears until the response lands;
    // gated by rst_n so it drops the instant reset is asserted.
    assign stall_o = rst_n & ((in_idle & access & fmt_legal) |
                              (state_q == REQ) | (state_q == WAIT));

    // Transaction FSM with registered bus outputs, load result and fault pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lane_q      <= '0;
            type_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_valid_q <= 1'b0;
            load_data_q <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            mem_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (fmt_legal) begin
                            addr_q      <= {addr_i[31:2], 2'b00};
                            lane_q      <= addr_i[1:0];
                            type_q      <= memType_i;
                            we_q        <= memWrite_i;
                            wdata_q     <= fmt_wdata;
                            be_q        <= fmt_be;
                            req_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end else begin
                            mem_fault_q <= 1'b1;
                            load_data_q <= '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid_i) begin
                        if (!we_q) load_data_q <= fmt_load;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign loadData_o       = load_data_q;
    assign memFault_o       = mem_fault_q;
    assign dmem_req_valid_o = req_valid_q;
    assign dmem_we_o        = we_q;
    assign dmem_addr_o      = addr_q;
    assign dmem_wdata_o     = wdata_q;
    assign dmem_be_o        = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of legal accesses with
// immediate handshakes, then hand-written delay, reset and illegal sequences.
module tb_mem_access_stage;
    import common_def::*;

    logic        clk;
    logic        rst_n;
    logic        memRead_i;
    logic        memWrite_i;
    logic [2:0]  memType_i;
    logic [31:0] addr_i;
    logic [31:0] storeData_i;
    logic        stall_o;
    logic [31:0] loadData_o;
    logic        memFault_o;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rdata_i;

    mem_access_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .memRead_i        (memRead_i),
        .memWrite_i       (memWrite_i),
        .memType_i        (memType_i),
        .addr_i           (addr_i),
        .storeData_i      (storeData_i),
        .stall_o          (stall_o),
        .loadData_o       (loadData_o),
        .memFault_o       (memFault_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rdata_i     (dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] exp_load;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    // Results observed by do_access
    int          stall_cnt, fault_cnt, req_cnt;
    logic        stable_ok, finished;
    logic [31:0] cap_addr, cap_wdata, done_load;
    logic [3:0]  cap_be;
    logic        cap_we;

    // One access through the full handshake. Starts in the cycle after the
    // current one so it follows a previous DONE back-to-back.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] typ,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] rword, input int rdy_dly, input int rsp_dly);
        logic accepted, responded;
        int   wait_cnt;
        @(posedge clk); #1;
        memRead_i = rd; memWrite_i = wr; memType_i = typ; addr_i = addr; storeData_i = sd;
        stall_cnt = 0; fault_cnt = 0; req_cnt = 0; wait_cnt = 0;
        stable_ok = 1'b1; finished = 1'b0; accepted = 1'b0; responded = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (stall_o)    stall_cnt++;
            if (memFault_o) fault_cnt++;
            if (dmem_req_valid_o) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    cap_addr = dmem_addr_o; cap_wdata = dmem_wdata_o;
                    cap_be = dmem_be_o; cap_we = dmem_we_o;
                end else if (cap_addr !== dmem_addr_o || cap_wdata !== dmem_wdata_o ||
                             cap_be !== dmem_be_o || cap_we !== dmem_we_o) begin
                    stable_ok = 1'b0;
                end
                dmem_req_ready_i = (req_cnt > rdy_dly);
                if (dmem_req_ready_i) accepted = 1'b1;
            end else if (accepted && !responded) begin
                dmem_req_ready_i = 1'b0;
                wait_cnt++;
                dmem_rdata_i     = rword;
                dmem_rsp_valid_i = (wait_cnt > rsp_dly);
                if (dmem_rsp_valid_i) responded = 1'b1;
            end else if (responded) begin
                dmem_rsp_valid_i = 1'b0;
                dmem_rdata_i     = 32'h0;
                done_load        = loadData_o;
                memRead_i = 1'b0; memWrite_i = 1'b0;
                finished = 1'b1;
            end
        end
        if (!finished) begin
            check("transaction_timeout", 32'd0, 32'd1);
            memRead_i = 1'b0; memWrite_i = 1'b0;
            dmem_req_ready_i = 1'b0; dmem_rsp_valid_i = 1'b0;
        end
    endtask

    // Illegal access presented for one cycle; watch for the fault pulse.
    task automatic do_illegal(input string name, input logic rd, input logic wr,
                              input logic [2:0] typ, input logic [31:0] addr);
        int f = 0, s = 0, r = 0;
        @(posedge clk); #1;
        memRead_i = rd; memWrite_i = wr; memType_i = typ; addr_i = addr; storeData_i = 32'h11223344;
        @(negedge clk);
        if (stall_o) s++; if (memFault_o) f++; if (dmem_req_valid_o) r++;
        @(posedge clk); #1;
        memRead_i = 1'b0; memWrite_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall_o) s++; if (memFault_o) f++; if (dmem_req_valid_o) r++;
        end
        check({name, "_fault_pulses"}, f, 1);
        check({name, "_stall_cycles"}, s, 0);
        check({name, "_req_cycles"}, r, 0);
        check({name, "_loadData"}, loadData_o, 32'h0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"LW_100",  1, 0, MEM_W,  32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h0,        4'b1111};
        vecs[1]  = '{"LB_103",  1, 0, MEM_B,  32'h103, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 32'h100, 32'h0,        4'b1111};
        vecs[2]  = '{"LBU_103", 1, 0, MEM_BU, 32'h103, 32'h0,        32'h80FF1234, 32'h00000080, 32'h100, 32'h0,        4'b1111};
        vecs[3]  = '{"LH_102",  1, 0, MEM_H,  32'h102, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 32'h100, 32'h0,        4'b1111};
        vecs[4]  = '{"LHU_102", 1, 0, MEM_HU, 32'h102, 32'h0,        32'h80FF1234, 32'h000080FF, 32'h100, 32'h0,        4'b1111};
        vecs[5]  = '{"LB_101",  1, 0, MEM_B,  32'h101, 32'h0,        32'h80FF1234, 32'h00000012, 32'h100, 32'h0,        4'b1111};
        vecs[6]  = '{"LH_100",  1, 0, MEM_H,  32'h100, 32'h0,        32'h80FF8234, 32'hFFFF8234, 32'h100, 32'h0,        4'b1111};
        // Stores leave loadData at the previous load result
        vecs[7]  = '{"SH_202",  0, 1, MEM_H,  32'h202, 32'h0000ABCD, 32'h5555AAAA, 32'hFFFF8234, 32'h200, 32'hABCDABCD, 4'b1100};
        vecs[8]  = '{"SB_301",  0, 1, MEM_B,  32'h301, 32'h123456A5, 32'h5555AAAA, 32'hFFFF8234, 32'h300, 32'hA5A5A5A5, 4'b0010};
        vecs[9]  = '{"SW_404",  0, 1, MEM_W,  32'h404, 32'hCAFEF00D, 32'h5555AAAA, 32'hFFFF8234, 32'h404, 32'hCAFEF00D, 4'b1111};
        vecs[10] = '{"LW_408",  1, 0, MEM_W,  32'h408, 32'h0,        32'h0BADC0DE, 32'h0BADC0DE, 32'h408, 32'h0,        4'b1111};

        rst_n = 1'b0;
        memRead_i = 1'b0; memWrite_i = 1'b0; memType_i = 3'b000;
        addr_i = 32'h0; storeData_i = 32'h0;
        dmem_req_ready_i = 1'b0; dmem_rsp_valid_i = 1'b0; dmem_rdata_i = 32'h0;

        // Reset values
        #3;
        check("rst_stall", stall_o, 0);
        check("rst_loadData", loadData_o, 0);
        check("rst_memFault", memFault_o, 0);
        check("rst_req_valid", dmem_req_valid_o, 0);
        check("rst_we", dmem_we_o, 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_wdata", dmem_wdata_o, 0);
        check("rst_be", dmem_be_o, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Table: minimum-latency transactions, issued back-to-back
        for (int i = 0; i < 11; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].typ, vecs[i].addr,
                      vecs[i].sdata, vecs[i].rdata, 0, 0);
            check({vecs[i].name, "_stall_cycles"}, stall_cnt, 3);
            check({vecs[i].name, "_req_cycles"}, req_cnt, 1);
            check({vecs[i].name, "_loadData"}, done_load, vecs[i].exp_load);
            check({vecs[i].name, "_addr"}, cap_addr, vecs[i].exp_addr);
            check({vecs[i].name, "_be"}, {28'd0, cap_be}, {28'd0, vecs[i].exp_be});
            check({vecs[i].name, "_we"}, {31'd0, cap_we}, {31'd0, vecs[i].wr});
            if (vecs[i].wr) check({vecs[i].name, "_wdata"}, cap_wdata, vecs[i].exp_wdata);
        end

        // Ready low 3 cycles, response 2 cycles late
        do_access(1'b1, 1'b0, MEM_W, 32'h500, 32'h0, 32'h13579BDF, 3, 2);
        check("slow_stall_cycles", stall_cnt, 8);
        check("slow_req_cycles", req_cnt, 4);
        check("slow_req_stable", {31'd0, stable_ok}, 1);
        check("slow_loadData", done_load, 32'h13579BDF);

        // Reset asserted while in REQ: valid drops without ready
        @(posedge clk); #1;
        memRead_i = 1'b1; memType_i = MEM_W; addr_i = 32'h600;
        @(negedge clk);
        @(negedge clk);
        check("rstreq_valid_before", dmem_req_valid_o, 1);
        #2 rst_n = 1'b0; memRead_i = 1'b0;
        #1;
        check("rstreq_valid", dmem_req_valid_o, 0);
        check("rstreq_stall", stall_o, 0);
        check("rstreq_loadData", loadData_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Load a nonzero result, then reset while in WAIT
        do_access(1'b1, 1'b0, MEM_W, 32'h700, 32'h0, 32'h24681357, 0, 0);
        check("preload_loadData", done_load, 32'h24681357);
        @(posedge clk); #1;
        memRead_i = 1'b1; memType_i = MEM_W; addr_i = 32'h704;
        @(negedge clk);
        @(negedge clk);
        dmem_req_ready_i = 1'b1;
        @(negedge clk);
        dmem_req_ready_i = 1'b0;
        check("rstwait_stall_before", stall_o, 1);
        #2 rst_n = 1'b0; memRead_i = 1'b0;
        #1;
        check("rstwait_stall", stall_o, 0);
        check("rstwait_valid", dmem_req_valid_o, 0);
        check("rstwait_loadData", loadData_o, 0);
        check("rstwait_addr", dmem_addr_o, 0);
        @(negedge clk); rst_n = 1'b1;
        // Stray response after reset is ignored
        dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk); @(negedge clk);
        check("stray_rsp_loadData", loadData_o, 0);
        check("stray_rsp_stall", stall_o, 0);
        check("stray_rsp_valid", dmem_req_valid_o, 0);
        dmem_rsp_valid_i = 1'b0; dmem_rdata_i = 32'h0;

        // Illegal accesses: fault pulse, no request, no stall, loadData cleared
        do_access(1'b1, 1'b0, MEM_W, 32'h800, 32'h0, 32'h99999999, 0, 0);
        check("preillegal_loadData", done_load, 32'h99999999);
        do_illegal("LW_102", 1'b1, 1'b0, MEM_W, 32'h102);
        do_illegal("LH_101", 1'b1, 1'b0, MEM_H, 32'h101);
        do_illegal("SHU_100", 1'b0, 1'b1, MEM_HU, 32'h100);
        do_illegal("type011", 1'b1, 1'b0, 3'b011, 32'h100);
        do_illegal("rd_and_wr", 1'b1, 1'b1, MEM_W, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
